// File: rtl/scope_trig_capture.sv
// Oscilloscope capture engine.
// A runtime divider derives the ADC sample strobe and adc_clk from clk.
// Samples are streamed into a circular RAM, and a trigger (level/edge or auto
// timeout) marks the frame position while a pre-trigger window is kept.
// The frozen frame is read by trigger-relative address.
module scope_trig_capture #(
    parameter  int DATA_W   = 8,
    parameter  int DEPTH    = 1024,
    parameter  int PRE_TRIG = 256,
    parameter  int DIV_W    = 16,
    parameter  int AUTO_TO  = 4096,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_din,
    output logic              adc_clk,
    input  logic [DIV_W-1:0]  div_sel,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic              trig_auto,
    input  logic              arm,
    input  logic              rd_release,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              capture_done,
    output logic              trig_forced,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam int AUTO_W    = $clog2(AUTO_TO + 1);
    localparam int POST_LEN  = DEPTH - PRE_TRIG - 1;
    localparam bit NO_POST   = (POST_LEN == 0);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(NO_POST ? 0 : POST_LEN - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TO - 1);

    // Divider state
    logic [DIV_W-1:0]  period;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              stb;
    logic              adc_clk_q;

    // Capture state
    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] start_ptr_q;
    logic [ADDR_W-1:0] smp_cnt_q;
    logic [AUTO_W-1:0] auto_cnt_q;
    logic [DATA_W-1:0] prev_q;
    logic              capture_done_q;
    logic              trig_forced_q;
    logic [DATA_W-1:0] rd_data_q;

    // Frame storage
    logic [DATA_W-1:0] mem [DEPTH];

    logic              we;
    logic              edge_hit;
    logic              auto_hit;
    logic [ADDR_W-1:0] rd_idx;

    // Divider next-state: wrap when the count reaches (or overshoots) the live period.
    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        period    = (div_sel == '0) ? DIV_W'(1) : div_sel;
        stb       = (div_cnt_q >= period);
        div_cnt_d = stb ? '0 : div_cnt_q + DIV_W'(1);
    end

    // Divider registers; adc_clk is the registered "second half of the period" flag.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            adc_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            adc_clk_q <= (div_cnt_d > (period >> 1));
        end
    end

    // Sample write enable and trigger qualification for the current strobe.
    always_comb begin
        we       = stb && !arm &&
                   ((state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST));
        edge_hit = trig_edge ? ((prev_q >= trig_level) && (adc_din <  trig_level))
                             : ((prev_q <  trig_level) && (adc_din >= trig_level));
        auto_hit = trig_auto && (auto_cnt_q >= AUTO_LAST);
        rd_idx   = start_ptr_q + rd_addr;
    end

    // Capture FSM with registered status outputs; arm overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            start_ptr_q    <= '0;
            smp_cnt_q      <= '0;
            auto_cnt_q     <= '0;
            prev_q         <= '0;
            capture_done_q <= 1'b0;
            trig_forced_q  <= 1'b0;
        end else begin
            if (we) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                prev_q   <= adc_din;
            end
            if (arm) begin
                state_q        <= S_PRE;
                smp_cnt_q      <= '0;
                auto_cnt_q     <= '0;
                capture_done_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_PRE: if (stb) begin
                        if (smp_cnt_q == PRE_LAST) begin
                            state_q   <= S_WAIT;
                            smp_cnt_q <= '0;
                        end else begin
                            smp_cnt_q <= smp_cnt_q + ADDR_W'(1);
                        end
                    end
                    S_WAIT: if (stb) begin
                        if (edge_hit || auto_hit) begin
                            // Current sample is written at wr_ptr_q and becomes the trigger.
                            start_ptr_q   <= wr_ptr_q - PRE_OFS;
                            trig_forced_q <= !edge_hit;
                            smp_cnt_q     <= '0;
                            if (NO_POST) begin
                                state_q        <= S_DONE;
                                capture_done_q <= 1'b1;
                            end else begin
                                state_q <= S_POST;
                            end
                        end else if (auto_cnt_q < AUTO_LAST) begin
                            auto_cnt_q <= auto_cnt_q + AUTO_W'(1);
                        end
                    end
                    S_POST: if (stb) begin
                        if (smp_cnt_q == POST_LAST) begin
                            state_q        <= S_DONE;
                            capture_done_q <= 1'b1;
                        end else begin
                            smp_cnt_q <= smp_cnt_q + ADDR_W'(1);
                        end
                    end
                    S_DONE: if (rd_release) begin
                        state_q        <= S_IDLE;
                        capture_done_q <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Sample RAM write port.
    // NOTE: the memory array has no reset; only the pointers that index it are cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr_q] <= adc_din;
        end
    end

    // Trigger-relative synchronous read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign adc_clk      = adc_clk_q;
    assign rd_data      = rd_data_q;
    assign capture_done = capture_done_q;
    assign trig_forced  = trig_forced_q;
    assign state        = state_q;

endmodule

// File: tb/tb_scope_trig_capture.sv
// Self-checking bench for scope_trig_capture (DEPTH=16, PRE_TRIG=4, AUTO_TO=32).
// A recorder logs every sample the capture should store since the last arm;
// the expected frame is found by searching that log for the trigger.
module tb_scope_trig_capture;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int PRE_TRIG = 4;
    localparam int DIV_W    = 16;
    localparam int AUTO_TO  = 32;
    localparam int ADDR_W   = 4;
    localparam int BUDGET   = 4000;

    typedef enum int {G_RAMP, G_CONST, G_STEP, G_RAND, G_LOWTHEN} gen_e;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] adc_din;
    logic              adc_clk;
    logic [DIV_W-1:0]  div_sel;
    logic [DATA_W-1:0] trig_level;
    logic              trig_edge;
    logic              trig_auto;
    logic              arm;
    logic              rd_release;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              capture_done;
    logic              trig_forced;
    logic [2:0]        state;

    int n_vec  = 0;
    int n_miss = 0;
    int k      = 0;

    scope_trig_capture #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG),
        .DIV_W(DIV_W), .AUTO_TO(AUTO_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .adc_din(adc_din), .adc_clk(adc_clk),
        .div_sel(div_sel), .trig_level(trig_level), .trig_edge(trig_edge),
        .trig_auto(trig_auto), .arm(arm), .rd_release(rd_release),
        .rd_addr(rd_addr), .rd_data(rd_data), .capture_done(capture_done),
        .trig_forced(trig_forced), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Strobe timing: one sample every max(div_sel,1)+1 clocks.
    logic [DIV_W-1:0]  m_cnt;
    logic [DIV_W-1:0]  m_p;
    logic              m_stb;
    assign m_p   = (div_sel == 0) ? DIV_W'(1) : div_sel;
    assign m_stb = (m_cnt >= m_p);

    logic [DATA_W-1:0] hist[$];
    logic [DATA_W-1:0] sb[$];
    bit                rec;
    bit                rd_req;
    bit                rd_pend;

    // Recorder: log of samples taken on strobes after an arm.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= '0;
            rec     <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            m_cnt   <= m_stb ? '0 : m_cnt + DIV_W'(1);
            rd_pend <= rd_req;
            if (arm) begin
                rec <= 1'b1;
                hist.delete();
            end else if (rec && m_stb && hist.size() < 4096) begin
                hist.push_back(adc_din);
            end
        end
    end

    // Monitor: each read issued one clock earlier presents rd_data now.
    always @(negedge clk) begin : mon
        logic [DATA_W-1:0] e;
        if (rd_pend) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rd_data", int'(rd_data), int'(e));
            end
        end
    end

    function automatic logic [DATA_W-1:0] gen(gen_e m, int idx, int a, int b, int n);
        case (m)
            G_RAMP:    return DATA_W'(idx);
            G_CONST:   return DATA_W'(a);
            G_STEP:    return (idx < n) ? DATA_W'(a) : DATA_W'(b);
            G_RAND:    return DATA_W'($urandom_range(255));
            G_LOWTHEN: return (idx < n) ? DATA_W'($urandom_range(a)) : DATA_W'(b);
            default:   return '0;
        endcase
    endfunction

    // Find the trigger in the log: first WAIT sample with the requested edge,
    // or the AUTO_TO-th WAIT sample when auto is enabled.
    task automatic find_trigger(input int lvl, input bit edg, input bit aut,
                                output int tidx, output bit forced);
        tidx   = -1;
        forced = 1'b0;
        for (int i = PRE_TRIG; i < hist.size(); i++) begin
            int p, c;
            p = int'(hist[i-1]);
            c = int'(hist[i]);
            if (edg ? (p >= lvl && c < lvl) : (p < lvl && c >= lvl)) begin
                tidx = i;
                return;
            end
            if (aut && (i - PRE_TRIG + 1) >= AUTO_TO) begin
                tidx   = i;
                forced = 1'b1;
                return;
            end
        end
    endtask

    // abort: 0 normal release, 1 re-arm while in POST, 2 arm+release together in DONE.
    task automatic capture(input string tag, input gen_e m, input int a, input int b,
                           input int n, input int lvl, input bit edg, input bit aut,
                           input int dsel, input int abort);
        int  tidx;
        bit  forced;
        bit  rearmed;
        int  cyc;
        int  addr;
        rearmed = 1'b0;
        @(negedge clk);
        div_sel    = DIV_W'(dsel);
        trig_level = DATA_W'(lvl);
        trig_edge  = edg;
        trig_auto  = aut;
        arm        = 1'b1;
        k          = 0;
        if (m_stb) adc_din = gen(m, k++, a, b, n);
        @(negedge clk);
        arm = 1'b0;
        check({tag, "_armed_state"}, int'(state), 1);
        check({tag, "_armed_done"}, int'(capture_done), 0);
        for (cyc = 0; cyc < BUDGET && !capture_done; cyc++) begin
            if (m_stb) adc_din = gen(m, k++, a, b, n);
            if (abort == 1 && !rearmed && state == 3'd3) begin
                arm     = 1'b1;
                rearmed = 1'b1;
            end
            @(negedge clk);
            if (arm) begin
                arm = 1'b0;
                check({tag, "_rearm_state"}, int'(state), 1);
                check({tag, "_rearm_done"}, int'(capture_done), 0);
            end
        end
        if (!capture_done) begin
            check({tag, "_done_timeout"}, 0, 1);
            return;
        end
        if (abort == 1) check({tag, "_rearm_seen"}, int'(rearmed), 1);
        find_trigger(lvl, edg, aut, tidx, forced);
        if (tidx < 0) begin
            check({tag, "_no_trigger_in_log"}, 0, 1);
            return;
        end
        check({tag, "_frame_len"}, hist.size(), tidx + DEPTH - PRE_TRIG);
        check({tag, "_state_done"}, int'(state), 4);
        check({tag, "_trig_forced"}, int'(trig_forced), int'(forced));
        if (hist.size() >= tidx + DEPTH - PRE_TRIG) begin
            for (int i = 0; i < DEPTH + 4; i++) begin
                addr = (i < DEPTH) ? i : $urandom_range(DEPTH - 1);
                sb.push_back(hist[tidx - PRE_TRIG + addr]);
                rd_addr = ADDR_W'(addr);
                rd_req  = 1'b1;
                @(negedge clk);
            end
            rd_req = 1'b0;
            repeat (2) @(negedge clk);
            check({tag, "_sb_drained"}, sb.size(), 0);
        end
        @(negedge clk);
        if (abort == 2) begin
            arm        = 1'b1;
            rd_release = 1'b1;
            @(negedge clk);
            arm        = 1'b0;
            rd_release = 1'b0;
            check({tag, "_arm_rel_state"}, int'(state), 1);
        end else begin
            rd_release = 1'b1;
            @(negedge clk);
            rd_release = 1'b0;
            check({tag, "_rel_state"}, int'(state), 0);
            check({tag, "_rel_done"}, int'(capture_done), 0);
        end
    endtask

    // adc_clk period and high time, counted in clk cycles between rising edges.
    task automatic measure(input string tag, input int dsel, input int exp_per, input int exp_hi);
        int t, per, hi;
        bit prev;
        @(negedge clk);
        div_sel = DIV_W'(dsel);
        repeat (20) @(negedge clk);
        prev = adc_clk;
        @(negedge clk);
        t = 0;
        while (!(adc_clk && !prev) && t < 100) begin
            prev = adc_clk;
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            check({tag, "_edge_timeout"}, 0, 1);
            return;
        end
        per = 0;
        hi  = 0;
        do begin
            if (adc_clk) hi++;
            per++;
            prev = adc_clk;
            @(negedge clk);
        end while (!(adc_clk && !prev) && per < 100);
        check({tag, "_period"}, per, exp_per);
        check({tag, "_high"}, hi, exp_hi);
    endtask

    task automatic reset_mid_post();
        int cyc;
        @(negedge clk);
        div_sel    = DIV_W'(1);
        trig_level = DATA_W'(200);
        trig_edge  = 1'b0;
        trig_auto  = 1'b1;
        rd_addr    = ADDR_W'(5);
        arm        = 1'b1;
        adc_din    = DATA_W'(77);
        @(negedge clk);
        arm = 1'b0;
        for (cyc = 0; cyc < BUDGET && state != 3'd3; cyc++) @(negedge clk);
        check("rst_reach_post", int'(state), 3);
        check("rst_pre_forced", int'(trig_forced), 1);
        rst_n = 1'b0;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_adc_clk", int'(adc_clk), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_done", int'(capture_done), 0);
        check("rst_forced", int'(trig_forced), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stays_idle", int'(state), 0);
    endtask

    initial begin : watchdog
        #5_000_000;
        n_miss++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : stim
        rst_n      = 1'b0;
        adc_din    = '0;
        div_sel    = DIV_W'(3);
        trig_level = '0;
        trig_edge  = 1'b0;
        trig_auto  = 1'b0;
        arm        = 1'b0;
        rd_release = 1'b0;
        rd_addr    = '0;
        rd_req     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", int'(state), 0);
        check("reset_adc_clk", int'(adc_clk), 0);
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_done", int'(capture_done), 0);
        check("reset_forced", int'(trig_forced), 0);
        rst_n = 1'b1;

        measure("div3", 3, 4, 2);
        measure("div0", 0, 2, 1);
        measure("div1", 1, 2, 1);
        measure("div5", 5, 6, 3);

        capture("ramp", G_RAMP, 0, 0, 0, 100, 1'b0, 1'b0, 1, 0);
        capture("fall", G_STEP, 200, 10, 12, 50, 1'b1, 1'b0, 2, 0);
        capture("auto", G_CONST, 77, 0, 0, 100, 1'b0, 1'b1, 0, 0);
        capture("wrap", G_LOWTHEN, 150, 220, 70, 200, 1'b0, 1'b0, 1, 0);
        for (int r = 0; r < 6; r++) begin
            capture("rand", G_RAND, 0, 0, 0, $urandom_range(255), 1'($urandom_range(1)),
                    1'b1, $urandom_range(3), 0);
        end
        capture("rearm", G_RAND, 0, 0, 0, 128, 1'b0, 1'b1, 1, 1);
        capture("armrel", G_CONST, 33, 0, 0, 100, 1'b0, 1'b1, 1, 2);
        reset_mid_post();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
